sub32_seq: RTL and testbench
============================

SUB32_SEQ -- requirements
Module: sub32_seq

Interface
REQ-001 Parameter SLICE_W, default 8, sets the bits processed per cycle; legal values are 1, 2, 4, 8, 16 and 32, and NSL = 32/SLICE_W.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  32  minuend; sampled on the accepting edge.
REQ-006 b  input  32  subtrahend; sampled on the accepting edge.
REQ-007 diff  output  32  registered result, a - b mod 2^32.
REQ-008 borrow  output  1  registered; 1 iff a < b (unsigned).
REQ-009 ovf  output  1  registered; signed two's-complement overflow.
REQ-010 zero  output  1  registered; 1 iff diff == 0.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge SHALL latch a, b and ~b, clear the slice counter, preset carry to 1 and go to RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-015 Each RUN edge SHALL compute slice k as a_k + ~b_k + carry into a working register, update the carry and increment k.
REQ-016 RUN SHALL last exactly NSL cycles; the edge that processes slice NSL-1 SHALL go to DONE.
REQ-017 Entry to DONE SHALL load diff, borrow, ovf and zero together; no output register changes during RUN.
REQ-018 borrow SHALL equal the inverse of the final carry out of bit 31.
REQ-019 ovf SHALL equal (a[31] != b[31]) AND (diff[31] != a[31]), using the latched operands.
REQ-020 zero SHALL equal NOR of all 32 result bits.
REQ-021 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-022 Latency: start accepted at edge E0 gives busy=1 from E0 to E_NSL and done=1 from E_NSL to E_NSL+1 (NSL=4 gives done 4 cycles after accept).
REQ-023 start in RUN or DONE SHALL be ignored and not queued; a new request SHALL be accepted only in IDLE, so back-to-back throughput is one operation per NSL+2 cycles.
REQ-024 Changes on a or b after the accepting edge SHALL NOT affect the operation in progress.
REQ-025 diff and all flags SHALL hold their last values until the next DONE entry.
REQ-026 busy and done SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and clear diff, borrow, ovf, zero, busy, done, the slice counter and the working registers, regardless of start.
REQ-028 rst during RUN or DONE SHALL abort the operation with no done pulse; rst has priority over start.
REQ-029 The first edge after rst deasserts with start=1 SHALL accept a request normally.

Verification
REQ-030 a=5, b=3, SLICE_W=8 -> diff=0x00000002, borrow=0, ovf=0, zero=0; done exactly 4 cycles after accept; busy high for 4 cycles.
REQ-031 a=0, b=1 -> diff=0xFFFFFFFF, borrow=1, ovf=0, zero=0; a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, ovf=1.
REQ-032 a=b=0x12345678 -> diff=0, zero=1, borrow=0, ovf=0; a=0x00000100, b=1 -> diff=0x000000FF, which checks borrow propagation across a slice boundary.
REQ-033 Rerun REQ-030 to REQ-032 with SLICE_W=1 and with SLICE_W=32 -> identical results, done at 32 and 1 cycles after accept respectively.
REQ-034 start held high continuously -> one accept per 6 cycles (SLICE_W=8); with a and b changed during RUN -> result matches the operands latched at accept.
REQ-035 rst pulsed on the 2nd RUN cycle -> no done, all outputs 0 the next cycle; start on the following edge with a=9, b=4 -> diff=5 after a normal latency.

Source files
------------

// File: rtl/sub32_seq.sv
// rtl/sub32_seq.sv - 32-bit sequential subtractor processing SLICE_W bits per cycle
module sub32_seq #(
    parameter int SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        borrow,
    output logic        ovf,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam int NSL   = 32 / SLICE_W;
    localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands are kept as right-shifting registers so the active slice is
    // always in the low bits; only the sign bits are kept separately for ovf.
    logic [31:0]        a_sh;
    logic [31:0]        nb_sh;
    logic               a_msb;
    logic               b_msb;
    logic [31:0]        res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   k_q;

    logic [SLICE_W:0]   slice_sum;
    logic [31:0]        res_nxt;
    logic               last_slice;

    // Slice adder: a_k + ~b_k + carry, result shifted in from the top
    always_comb begin
        slice_sum  = {1'b0, a_sh[SLICE_W-1:0]}
                   + {1'b0, nb_sh[SLICE_W-1:0]}
                   + {{SLICE_W{1'b0}}, carry_q};
        res_nxt    = (res_q >> SLICE_W)
                   | (32'(slice_sum[SLICE_W-1:0]) << (32 - SLICE_W));
        last_slice = (k_q == K_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, slice processing and result/flag load on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            nb_sh   <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        nb_sh   <= ~b;
                        a_msb   <= a[31];
                        b_msb   <= b[31];
                        res_q   <= '0;
                        carry_q <= 1'b1;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> SLICE_W;
                    nb_sh   <= nb_sh >> SLICE_W;
                    res_q   <= res_nxt;
                    carry_q <= slice_sum[SLICE_W];
                    k_q     <= k_q + CNT_W'(1);
                    if (last_slice) begin
                        diff   <= res_nxt;
                        borrow <= ~slice_sum[SLICE_W];
                        ovf    <= (a_msb != b_msb) && (res_nxt[31] != a_msb);
                        zero   <= ~|res_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_seq.sv
// tb/tb_sub32_seq.sv - bench for sub32_seq at SLICE_W = 1, 8 and 32
module tb_sub32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] diff_o   [3];
    logic        borrow_o [3];
    logic        ovf_o    [3];
    logic        zero_o   [3];
    logic        busy_o   [3];
    logic        done_o   [3];

    int n_vec  = 0;
    int n_bad  = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;

    int sws [3] = '{1, 8, 32};
    int nsl [3] = '{32, 4, 1};

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    // model state: accept edge and expected held outputs per instance
    int          t0       [3] = '{-1000, -1000, -1000};
    logic [31:0] pa       [3];
    logic [31:0] pb       [3];
    logic [31:0] m_diff   [3] = '{0, 0, 0};
    logic        m_borrow [3] = '{0, 0, 0};
    logic        m_ovf    [3] = '{0, 0, 0};
    logic        m_zero   [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    sub32_seq #(.SLICE_W(1)) u_sw1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff_o[0]), .borrow(borrow_o[0]), .ovf(ovf_o[0]),
        .zero(zero_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    sub32_seq #(.SLICE_W(8)) u_sw8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff_o[1]), .borrow(borrow_o[1]), .ovf(ovf_o[1]),
        .zero(zero_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    sub32_seq #(.SLICE_W(32)) u_sw32 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff_o[2]), .borrow(borrow_o[2]), .ovf(ovf_o[2]),
        .zero(zero_o[2]), .busy(busy_o[2]), .done(done_o[2])
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s sw=%0d edge=%0d: got %h required %h", nm, sws[idx], edge_n, act, exp);
        end
    endtask

    // Model: an operation accepted at edge t0 finishes at edge t0+NSL and the
    // unit is free again from edge t0+NSL+2.
    always @(posedge clk) begin : model
        longint sd;
        edge_n = edge_n + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                t0[i]       = -1000;
                m_diff[i]   = '0;
                m_borrow[i] = 1'b0;
                m_ovf[i]    = 1'b0;
                m_zero[i]   = 1'b0;
            end else if (start && edge_n >= t0[i] + nsl[i] + 2) begin
                t0[i] = edge_n;
                pa[i] = a;
                pb[i] = b;
            end else if (edge_n == t0[i] + nsl[i]) begin
                m_diff[i]   = pa[i] - pb[i];
                m_borrow[i] = (pa[i] < pb[i]);
                sd          = longint'($signed(pa[i])) - longint'($signed(pb[i]));
                m_ovf[i]    = (sd > SMAX) || (sd < SMIN);
                m_zero[i]   = (pa[i] == pb[i]);
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin : cmp
        logic eb;
        logic ed;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                eb = (edge_n >= t0[i]) && (edge_n < t0[i] + nsl[i]);
                ed = (edge_n == t0[i] + nsl[i]);
                chk("busy",   i, 32'(busy_o[i]),   32'(eb));
                chk("done",   i, 32'(done_o[i]),   32'(ed));
                chk("diff",   i, diff_o[i],        m_diff[i]);
                chk("borrow", i, 32'(borrow_o[i]), 32'(m_borrow[i]));
                chk("ovf",    i, 32'(ovf_o[i]),    32'(m_ovf[i]));
                chk("zero",   i, 32'(zero_o[i]),   32'(m_zero[i]));
            end
        end
    end

    task automatic run_op(input bit pre_wait, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] xd, input logic xb, input logic xo, input logic xz);
        int lat [3];
        int bc  [3];
        if (pre_wait) @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            bc[i]  = 0;
        end
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            for (int i = 0; i < 3; i++) begin
                if (busy_o[i]) bc[i]++;
                if (done_o[i] && lat[i] < 0) lat[i] = n;
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            chk("latency",     i, lat[i],           nsl[i]);
            chk("busy_cycles", i, bc[i],            nsl[i]);
            chk("lit_diff",    i, diff_o[i],        xd);
            chk("lit_borrow",  i, 32'(borrow_o[i]), 32'(xb));
            chk("lit_ovf",     i, 32'(ovf_o[i]),    32'(xo));
            chk("lit_zero",    i, 32'(zero_o[i]),   32'(xz));
        end
        chk("model_diff", 1, m_diff[1], xd);
        chk("model_ovf",  1, 32'(m_ovf[1]), 32'(xo));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_diff",   i, diff_o[i],        32'h0);
            chk("rst_borrow", i, 32'(borrow_o[i]), 32'h0);
            chk("rst_ovf",    i, 32'(ovf_o[i]),    32'h0);
            chk("rst_zero",   i, 32'(zero_o[i]),   32'h0);
            chk("rst_busy",   i, 32'(busy_o[i]),   32'h0);
            chk("rst_done",   i, 32'(done_o[i]),   32'h0);
        end
        chk_en = 1'b1;
        rst    = 1'b0;

        run_op(1'b1, 32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'd0,          32'd1,          32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 32'h1234_5678,  32'h1234_5678,  32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_op(1'b1, 32'h0000_0100,  32'd1,          32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1, 1'b0);

        // start held high with operands changing every cycle
        @(negedge clk);
        a     = 32'd100;
        b     = 32'd42;
        start = 1'b1;
        dn    = 0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            if (done_o[1]) dn++;
        end
        start = 1'b0;
        chk("held_done_count", 1, dn, 4);
        repeat (40) @(negedge clk);

        // reset during the second RUN cycle aborts the operation
        a     = 32'd7;
        b     = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn    = 0;
        if (done_o[1]) dn++;
        @(negedge clk);
        if (done_o[1]) dn++;
        rst = 1'b1;
        @(negedge clk);
        if (done_o[1]) dn++;
        chk("abort_no_done", 1, dn, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_diff",   i, diff_o[i],        32'h0);
            chk("abort_borrow", i, 32'(borrow_o[i]), 32'h0);
            chk("abort_ovf",    i, 32'(ovf_o[i]),    32'h0);
            chk("abort_zero",   i, 32'(zero_o[i]),   32'h0);
            chk("abort_busy",   i, 32'(busy_o[i]),   32'h0);
            chk("abort_done",   i, 32'(done_o[i]),   32'h0);
        end
        rst = 1'b0;
        run_op(1'b0, 32'd9, 32'd4, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
